// File: rtl/mem_pkg.sv
// Shared types and elaboration checks for the synchronous scratch RAM.
package mem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } mem_state_e;

  function automatic bit rd_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-response pipeline: RD_LAT-deep valid/data shift register.
// Data stages load only with a valid beat, so the output holds between pulses.
module mem_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [RD_LAT:1]              vld_q;
  logic [RD_LAT:1][DATA_W-1:0]  dat_q;
  logic [RD_LAT:0]              vld_pipe;
  logic [RD_LAT:0][DATA_W-1:0]  dat_pipe;

  assign vld_pipe = {vld_q, in_valid};
  assign dat_pipe = {dat_q, in_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      for (int s = 1; s <= RD_LAT; s++) begin
        vld_q[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) dat_q[s] <= dat_pipe[s-1];
      end
    end
  end

  assign out_valid = vld_pipe[RD_LAT];
  assign out_data  = dat_pipe[RD_LAT];

endmodule

// File: rtl/mem_sync_rw.sv
// Single-port synchronous RAM with valid/ready request port, pipelined read
// response and a clear sequencer that zeroes every word after reset or on demand.
module mem_sync_rw
  import mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              clr_start,
  output logic              busy
);

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
    $error("mem_sync_rw: RD_LAT must be 1 or 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mem_sync_rw: DEPTH must be a power of two >= 2");
  end
  if (ADDR_W != $clog2(DEPTH)) begin : g_bad_aw
    $error("mem_sync_rw: ADDR_W is derived from DEPTH");
  end

  mem_state_e        state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == ST_CLEAR) ? cnt + 1'b1 : '0;
    end
  end

  // clr_start outranks a same-cycle request: ready drops combinationally
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    req_ready = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy = 1'b1;
        if (cnt == ADDR_W'(DEPTH - 1)) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        req_ready = !clr_start;
        if (clr_start) state_nxt = ST_CLEAR;
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  assign accept = req_valid && req_ready;

  // Array has no reset; the CLEAR walk zeroes it
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR)     mem[cnt]      <= '0;
    else if (accept && req_we) mem[req_addr] <= req_wdata;
  end

  assign rd_valid = accept && !req_we;
  assign rd_data  = mem[req_addr];

  mem_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_valid),
    .in_data   (rd_data),
    .out_valid (rsp_valid),
    .out_data  (rsp_rdata)
  );

endmodule

// File: tb/tb_mem_sync_rw.sv
// Scoreboard bench: one RD_LAT=1 and one RD_LAT=2 instance share stimulus and
// are checked against an array/counter reference model.
module tb_mem_sync_rw;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          clr_start = 1'b0;

  logic          rdy [2];
  logic          rv  [2];
  logic          bz  [2];
  logic [DW-1:0] rd  [2];

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  int clr_left = DEPTH;
  logic [DW-1:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  mem_sync_rw #(.DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .clr_start(clr_start), .busy(bz[0])
  );

  mem_sync_rw #(.DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .clr_start(clr_start), .busy(bz[1])
  );

  for (genvar g = 0; g < 2; g++) begin : lane
    exp_t          q[$];
    logic [DW-1:0] last = '0;

    always @(negedge clk) begin
      exp_t e;
      logic exp_busy, exp_rdy;
      if (rst) begin
        vecs++;
        if (rv[g] !== 1'b0 || rd[g] !== '0 || bz[g] !== 1'b1 || rdy[g] !== 1'b0) begin
          errs++;
          $display("FAIL reset_state lat%0d: got v=%b d=%h busy=%b rdy=%b want v=0 d=00 busy=1 rdy=0",
                   g + 1, rv[g], rd[g], bz[g], rdy[g]);
        end
        last = '0;
      end else begin
        exp_busy = (clr_left > 0);
        exp_rdy  = !exp_busy && !clr_start;
        vecs++;
        if (bz[g] !== exp_busy || rdy[g] !== exp_rdy) begin
          errs++;
          $display("FAIL busy_ready lat%0d cyc%0d: got busy=%b rdy=%b want busy=%b rdy=%b",
                   g + 1, cyc, bz[g], rdy[g], exp_busy, exp_rdy);
        end
        vecs++;
        if (rv[g] === 1'b1) begin
          if (q.size() == 0) begin
            errs++;
            $display("FAIL spurious_rsp lat%0d cyc%0d: got d=%h want no response", g + 1, cyc, rd[g]);
          end else begin
            e = q.pop_front();
            if (rd[g] !== e.d || cyc != e.due) begin
              errs++;
              $display("FAIL rsp_data lat%0d cyc%0d: got d=%h want d=%h at cyc%0d",
                       g + 1, cyc, rd[g], e.d, e.due);
            end
            last = e.d;
          end
        end else begin
          if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            errs++;
            $display("FAIL missing_rsp lat%0d cyc%0d: got rsp_valid=%b want d=%h", g + 1, cyc, rv[g], e.d);
          end
          if (rd[g] !== last) begin
            errs++;
            $display("FAIL rdata_hold lat%0d cyc%0d: got d=%h want d=%h", g + 1, cyc, rd[g], last);
          end
        end
      end
    end
  end

  // Reference: a clear blocks DEPTH edges; while idle, clr_start wins over a request
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_left = DEPTH;
      foreach (ref_mem[i]) ref_mem[i] = '0;
      lane[0].q.delete();
      lane[1].q.delete();
    end else begin
      cyc++;
      if (clr_left > 0) begin
        clr_left--;
      end else if (clr_start) begin
        clr_left = DEPTH;
        foreach (ref_mem[i]) ref_mem[i] = '0;
      end else if (req_valid) begin
        if (req_we) ref_mem[req_addr] = req_wdata;
        else begin
          lane[0].q.push_back('{ref_mem[req_addr], cyc});
          lane[1].q.push_back('{ref_mem[req_addr], cyc + 1});
        end
      end
    end
  end

  task automatic step(input logic v, input logic we, input int a, input int d, input logic c);
    req_valid = v;
    req_we    = we;
    req_addr  = AW'(a);
    req_wdata = DW'(d);
    clr_start = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) step(0, 0, 0, 0, 0);
    for (int a = 0; a < DEPTH; a++) step(1, 0, a, 0, 0);
    step(1, 1, 1, 'hA5, 0);
    step(1, 1, 2, 'h3C, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 2, 0, 0);
    step(1, 1, 3, 'h77, 0);
    step(1, 0, 3, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int a = 0; a < DEPTH; a++) step(1, 1, a, 'hFF, 0);
    step(1, 0, 0, 0, 1);
    repeat (DEPTH) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 2, 'h3C, 0);
    step(1, 0, 2, 0, 0);
    step(0, 0, 0, 0, 1);
    repeat (DEPTH) step(0, 0, 0, 0, 0);
    step(1, 0, 2, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    rst = 1'b0;
    repeat (DEPTH + 2) step(1, 0, 1, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 249) == 0) begin
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)),
           $urandom_range(0, 24) == 0);
    end
    repeat (8) step(0, 0, 0, 0, 0);
    for (int g = 0; g < 2; g++) begin
      int left;
      left = (g == 0) ? lane[0].q.size() : lane[1].q.size();
      vecs++;
      if (left != 0) begin
        errs++;
        $display("FAIL drain lat%0d: got %0d pending want 0", g + 1, left);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
